// File: rtl/pl_frame_filter.sv
// pl_frame_filter: POWERLINK frame header decoder and payload forwarder.
// Consumes a byte stream (destination MAC byte 0 first) and decodes the
// ethertype, message type and node IDs carried in header bytes 12..16. An
// accepted frame forwards up to PAYLOAD_MAX payload bytes.
// Optional macro PL_DST_FILTER_EN: when defined, a slave node (MASTER=0)
// rejects frames whose destination is neither NODE_ID nor broadcast 8'hFF.
module pl_frame_filter #(
    parameter logic [7:0] NODE_ID     = 8'h01,
    parameter bit         MASTER      = 1'b0,
    parameter logic [4:0] TYPE_EN     = 5'b11111,
    parameter int         PAYLOAD_MAX = 36
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    input  logic        rx_busy,
    output logic        head_o,
    output logic        hit_o,
    output logic [4:0]  type_o,
    output logic [7:0]  dst_o,
    output logic [7:0]  src_o,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        end_o,
    output logic [10:0] pl_len
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAD    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    localparam logic [10:0] PL_MAX = 11'(PAYLOAD_MAX);

    // One-hot message type, bit order {ASnd,SoA,PRes,PReq,SoC}; zero if unknown.
    function automatic logic [4:0] f_decode_type(input logic [6:0] code);
        logic [4:0] onehot;
        case (code)
            7'h01:   onehot = 5'b00001;
            7'h03:   onehot = 5'b00010;
            7'h04:   onehot = 5'b00100;
            7'h05:   onehot = 5'b01000;
            7'h06:   onehot = 5'b10000;
            default: onehot = 5'b00000;
        endcase
        return onehot;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic        r_busy_d;
    logic [11:0] r_idx;
    logic        r_fault;
    logic [4:0]  r_type_pend;
    logic [7:0]  r_dst_pend;
    logic [10:0] r_cnt;

    logic        w_start;
    logic        w_in_head;
    logic        w_take;
    logic        w_hbyte;
    logic        w_head;
    logic        w_fwd;
    logic        w_end;
    logic        w_byte_bad;
    logic [4:0]  w_type_dec;

    // A frame only starts on a fresh rising edge of rx_busy, so a frame cut
    // by reset is ignored until the line goes idle and busy again.
    assign w_start   = rx_busy & ~r_busy_d;
    assign w_in_head = (r_state == ST_HEAD) | ((r_state == ST_IDLE) & w_start);
    assign w_take    = rx_rdy & rx_busy & ((r_state != ST_IDLE) | w_start);
    assign w_hbyte   = w_take & w_in_head;
    assign w_head    = w_hbyte & (r_idx == 12'd16);
    assign w_fwd     = w_take & (r_state == ST_PAYLOAD) & (r_cnt < PL_MAX);
    assign w_end     = (r_state == ST_PAYLOAD) & ~rx_busy;
    assign w_type_dec = f_decode_type(rx_data[6:0]);

    // Per-byte header check: flags a byte that makes the frame faulty.
    always_comb begin
        w_byte_bad = 1'b0;
        case (r_idx)
            12'd12:  w_byte_bad = (rx_data != 8'h88);
            12'd13:  w_byte_bad = (rx_data != 8'hAB);
            12'd14:  w_byte_bad = ((w_type_dec & TYPE_EN) == 5'b00000);
`ifdef PL_DST_FILTER_EN
            12'd15:  w_byte_bad = !MASTER && (rx_data != NODE_ID) && (rx_data != 8'hFF);
`else
            12'd15:  w_byte_bad = 1'b0;
`endif
            default: w_byte_bad = 1'b0;
        endcase
    end

    // Next-state logic; a falling rx_busy always ends the frame.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_next = ST_HEAD;
                else         w_next = ST_IDLE;
            end
            ST_HEAD: begin
                if (!rx_busy)   w_next = ST_IDLE;
                else if (w_head) w_next = r_fault ? ST_DROP : ST_PAYLOAD;
                else            w_next = ST_HEAD;
            end
            ST_PAYLOAD: begin
                if (!rx_busy) w_next = ST_IDLE;
                else          w_next = ST_PAYLOAD;
            end
            ST_DROP: begin
                if (!rx_busy) w_next = ST_IDLE;
                else          w_next = ST_DROP;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register and busy edge detector (busy_d resets high so a frame
    // already in flight at reset release is not mistaken for a new one).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_busy_d <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_busy_d <= rx_busy;
        end
    end

    // Saturating byte index within the current frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 12'd0;
        end else if (!rx_busy) begin
            r_idx <= 12'd0;
        end else if (w_take && (r_idx != 12'd4095)) begin
            r_idx <= r_idx + 12'd1;
        end
    end

    // Header capture: fault flag, pending type and destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault     <= 1'b0;
            r_type_pend <= 5'b00000;
            r_dst_pend  <= 8'h00;
        end else begin
            if (r_state == ST_IDLE) begin
                r_fault <= 1'b0;
            end else if (w_hbyte && w_byte_bad) begin
                r_fault <= 1'b1;
            end
            if (w_hbyte && (r_idx == 12'd14)) r_type_pend <= w_type_dec;
            if (w_hbyte && (r_idx == 12'd15)) r_dst_pend  <= rx_data;
        end
    end

    // Verdict outputs, published once per frame when byte 16 is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_o <= 1'b0;
            hit_o  <= 1'b0;
            type_o <= 5'b00000;
            dst_o  <= 8'h00;
            src_o  <= 8'h00;
        end else begin
            head_o <= w_head;
            hit_o  <= w_head & ~r_fault;
            if (w_head) begin
                type_o <= r_fault ? 5'b00000 : r_type_pend;
                dst_o  <= r_dst_pend;
                src_o  <= rx_data;
            end
        end
    end

    // Payload forwarding, byte counter and end-of-frame report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pl_data  <= 8'h00;
            pl_valid <= 1'b0;
            r_cnt    <= 11'd0;
            end_o    <= 1'b0;
            pl_len   <= 11'd0;
        end else begin
            pl_valid <= w_fwd;
            end_o    <= w_end;
            if (w_fwd) pl_data <= rx_data;
            if (w_head) begin
                r_cnt <= 11'd0;
            end else if (w_fwd) begin
                r_cnt <= r_cnt + 11'd1;
            end
            if (w_end) pl_len <= r_cnt;
        end
    end

endmodule
